skid_pipe_chain: RTL and testbench
==================================

Name: skid_pipe_chain

Overview:
- Parametrised cascade of fully registered skid-buffer slices for valid/ready streams.
- Breaks the forward timing path (valid/data) and the backward timing path (ready) at every stage.
- Sustains 1 transfer/cycle with no bubbles.
- Drops into any valid/ready interface where long forward or backward paths need pipelining; replaces the earlier single-slice backward buffer.

Parameters:
- W, 8, payload width in bits (≥1).
- STAGES, 2, number of cascaded slices (1..16; any other value is an elaboration error).
- CNT_W, $clog2(2*STAGES+1), occupancy counter width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream data valid.
- in_ready  out  1  upstream may transfer; registered output.
- in_data  in  W  upstream payload.
- out_valid  out  1  downstream data valid; registered output.
- out_ready  in  1  downstream accepts.
- out_data  out  W  downstream payload; registered output.
- occupancy  out  CNT_W  number of words held, 0..2*STAGES.
- flush  in  1  synchronous clear; present only with SKID_PIPE_FLUSH_EN.

Behaviour:
- Transfer rule: a transfer happens on an edge where valid && ready at that interface.
- Reset state (rst low, asynchronous): all valid/skid flags 0; all data registers 0.
  - Outputs in reset: out_valid=0, out_data=0, in_ready=1, occupancy=0.
- Slice structure: each slice has a main register (drives its output) and a skid register. Slice k's output feeds slice k+1's input; the last slice drives out_*.
- Slice in_ready = !skid_valid, taken directly from a flop. No combinational path from out_ready to in_ready.
- Slice FSM, encoded by {main_valid, skid_valid}:
  - EMPTY (0,0): input transfer -> main=in, go to BUSY.
  - BUSY (1,0):
    - Input and output transfer together -> main=in, stay BUSY.
    - Input transfer only -> skid=in, go to FULL.
    - Output transfer only -> go to EMPTY.
    - Neither -> hold.
  - FULL (1,1): in_ready=0. Output transfer -> main=skid, go to BUSY. Otherwise hold.
  - (0,1) is illegal and unreachable; treat it as FULL for safety.
- Latency: one word passes through in STAGES cycles when there is no backpressure. Throughput is 1 word/cycle.
- Capacity: 2*STAGES words. in_ready of the chain falls exactly when slice 0 enters FULL.
- Ordering: strict FIFO order. No word is lost or duplicated.
- Data stability:
  - out_data and out_valid hold steady while out_valid=1 and out_ready=0.
  - Data registers load only on an accepting transfer; they are never loaded with garbage.
- Upstream rule: in_valid may be asserted/deasserted freely. in_data is sampled only on an in_valid && in_ready edge.
- occupancy: registered sum of all main_valid and skid_valid bits. It updates on the same edge as the state change. With simultaneous in and out transfers it is unchanged.
- Reset mid-stream: every in-flight word is discarded immediately (asynchronously). The first accepted word after rst rises appears on out_* after STAGES cycles.

Optional Feature:
- Macro: SKID_PIPE_FLUSH_EN.
- Defined:
  - flush port exists.
  - flush=1 at an edge clears every valid/skid flag and occupancy on that edge.
  - Any word presented on in_* in that cycle is dropped even if in_ready=1.
  - flush has priority over every transfer.
  - Data registers are not cleared.
  - out_valid=0 and in_ready=1 on the following cycle.
- Undefined: no flush port; behaviour is as above without flush.

Decomposition:
- Package skid_pipe_pkg:
  - slice_state_e enum (EMPTY, BUSY, FULL).
  - Function cnt_w(stages).
  - Localparam MAX_STAGES=16.
- Sub-module skid_slice (parameter W): one FSM slice with in/out valid/ready/data, a 2-bit occupancy contribution, and flush (under the macro).
- Top level: generate-for chain of STAGES slices plus an occupancy adder tree/register.

Test Plan:
- W=8, STAGES=2, out_ready=1, push 0x01..0x10 back-to-back -> out_data 0x01..0x10 in order.
  - First word appears on out_* 2 cycles after its transfer.
  - 1 word/cycle, in_ready stays 1.
- out_ready=0, push continuously -> exactly 4 words accepted, in_ready=0 after the 4th, occupancy=4.
  - out_data=first word, stable.
  - Release out_ready -> 4 words drain in order, in_ready back to 1 the cycle after slice 0 leaves FULL.
- Random in_valid/out_ready toggling (50%/50%), 10k words -> scoreboard matches exactly.
  - in_ready never depends combinationally on out_ready (check: out_ready toggled mid-cycle leaves in_ready unchanged).
- Occupancy=3 steady state with simultaneous in and out transfers -> occupancy stays 3 and data order is preserved.
- Hold 3 words, assert rst low between edges -> out_valid=0, occupancy=0 immediately.
  - Release, push 0xA5 -> 0xA5 out after 2 cycles.
- With SKID_PIPE_FLUSH_EN: 4 words held plus in_valid=1 with 0x77 on the flush cycle -> next cycle occupancy=0, out_valid=0, in_ready=1, and 0x77 never appears on out_*.

Source files
------------

// File: rtl/skid_pipe_chain_pkg.sv
// skid_pipe_pkg: shared types and sizing helpers for the skid pipe chain
package skid_pipe_pkg;
    localparam int MAX_STAGES = 16;
    // encoding is {main_valid, skid_valid}
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b10,
        FULL  = 2'b11
    } slice_state_e;
    function automatic int cnt_w(input int stages);
        return $clog2(2 * stages + 1);
    endfunction
endpackage

// File: rtl/skid_pipe_chain_slice.sv
// skid_slice: one fully registered valid/ready slice with main and skid registers
// SKID_PIPE_FLUSH_EN adds a synchronous flush input that clears the flags.
module skid_slice
    import skid_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
`ifdef SKID_PIPE_FLUSH_EN
    input  logic         i_flush,
`endif
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [W-1:0] i_in_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [W-1:0] o_out_data,
    output logic [1:0]   o_occ_nxt
);
    slice_state_e r_state, w_state_nxt;
    logic [W-1:0] r_main, r_skid;
    logic         w_flush, w_in_fire, w_out_fire, w_ld_main, w_ld_skid, w_main_from_skid;

`ifdef SKID_PIPE_FLUSH_EN
    assign w_flush = i_flush;
`else
    assign w_flush = 1'b0;
`endif

    assign o_in_ready  = !r_state[0];
    assign o_out_valid = r_state[1];
    assign o_out_data  = r_main;
    assign w_in_fire   = i_in_valid && o_in_ready;
    assign w_out_fire  = o_out_valid && i_out_ready;
    assign o_occ_nxt   = {1'b0, w_state_nxt[1]} + {1'b0, w_state_nxt[0]};

    always_comb begin
        w_state_nxt      = r_state;
        w_ld_main        = 1'b0;
        w_ld_skid        = 1'b0;
        w_main_from_skid = 1'b0;
        if (w_flush) begin
            w_state_nxt = EMPTY;
        end else if (r_state[0]) begin
            // FULL; the unreachable (0,1) code also unloads its skid word
            if (w_out_fire || !r_state[1]) begin
                w_state_nxt      = BUSY;
                w_ld_main        = 1'b1;
                w_main_from_skid = 1'b1;
            end
        end else if (r_state[1]) begin
            if (w_in_fire && w_out_fire) begin
                w_ld_main = 1'b1;
            end else if (w_in_fire) begin
                w_ld_skid   = 1'b1;
                w_state_nxt = FULL;
            end else if (w_out_fire) begin
                w_state_nxt = EMPTY;
            end
        end else if (w_in_fire) begin
            w_ld_main   = 1'b1;
            w_state_nxt = BUSY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ld_main) r_main <= w_main_from_skid ? r_skid : i_in_data;
            if (w_ld_skid) r_skid <= i_in_data;
        end
    end
endmodule

// File: rtl/skid_pipe_chain.sv
// skid_pipe_chain: cascade of STAGES registered skid slices with an occupancy count
// SKID_PIPE_FLUSH_EN adds the synchronous flush port.
module skid_pipe_chain
    import skid_pipe_pkg::*;
#(
    parameter int W      = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = cnt_w(STAGES)
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SKID_PIPE_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [CNT_W-1:0] occupancy
);
    generate
        if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
            $error("skid_pipe_chain: STAGES must be in 1..%0d", MAX_STAGES);
        end
    endgenerate

    logic [STAGES:0] w_valid, w_ready;
    logic [W-1:0]    w_data [0:STAGES];
    logic [1:0]      w_occ [0:STAGES-1];
    logic [CNT_W-1:0] w_occ_sum, r_occ;

    assign w_valid[0]      = in_valid;
    assign in_ready        = w_ready[0];
    assign w_data[0]       = in_data;
    assign out_valid       = w_valid[STAGES];
    assign w_ready[STAGES] = out_ready;
    assign out_data        = w_data[STAGES];
    assign occupancy       = r_occ;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_slice
            skid_slice #(.W(W)) u_slice (
                .clk        (clk),
                .rst        (rst),
`ifdef SKID_PIPE_FLUSH_EN
                .i_flush    (flush),
`endif
                .i_in_valid (w_valid[k]),
                .o_in_ready (w_ready[k]),
                .i_in_data  (w_data[k]),
                .o_out_valid(w_valid[k+1]),
                .i_out_ready(w_ready[k+1]),
                .o_out_data (w_data[k+1]),
                .o_occ_nxt  (w_occ[k])
            );
        end
    endgenerate

    // summing next-state flags keeps the count aligned with the slice flops
    always_comb begin
        w_occ_sum = '0;
        for (int i = 0; i < STAGES; i++) w_occ_sum = w_occ_sum + CNT_W'(w_occ[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_occ <= '0;
        else r_occ <= w_occ_sum;
    end
endmodule

// File: tb/tb_skid_pipe_chain.sv
// tb_skid_pipe_chain: randomized scoreboard bench for skid_pipe_chain (W=8, STAGES=2)
module tb_skid_pipe_chain;
    localparam int W      = 8;
    localparam int STAGES = 2;
    localparam int CNT_W  = $clog2(2 * STAGES + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [W-1:0]     in_data = '0;
    logic             in_ready, out_valid;
    logic [W-1:0]     out_data;
    logic [CNT_W-1:0] occupancy;
`ifdef SKID_PIPE_FLUSH_EN
    logic             flush = 1'b0;
`endif

    int           n_cmp = 0;
    int           n_fail = 0;
    logic [W-1:0] q[$];
    logic [W-1:0] od, id, exp_d;
    logic         fi, fo;

    skid_pipe_chain #(.W(W), .STAGES(STAGES)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef SKID_PIPE_FLUSH_EN
        .flush    (flush),
`endif
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        fi = in_valid && in_ready;
        fo = out_valid && out_ready;
        od = out_data;
        id = in_data;
`ifdef SKID_PIPE_FLUSH_EN
        if (flush) fi = 1'b0;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #10;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL rst_out_data: got %h want 00", out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rst_occupancy: got %0d want 0", occupancy); end
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            in_valid = (e <= 16);
            in_data  = W'(e);
            tick();
            if (e <= 16) begin
                n_cmp++; if (!fi) begin n_fail++; $display("FAIL b2b_in_ready e=%0d: got 0 want 1", e); end
            end
            if (e >= 2 && e <= 17) begin
                n_cmp++; if (out_valid !== 1'b1 || out_data !== W'(e - 1)) begin n_fail++; $display("FAIL b2b_out e=%0d: got v=%b d=%h want v=1 d=%h", e, out_valid, out_data, W'(e - 1)); end
            end else begin
                n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle e=%0d: got v=%b want 0", e, out_valid); end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_fill_drain();
        int acc = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_data  = W'(32'h20 + acc);
            tick();
            if (fi) begin q.push_back(id); acc++; end
        end
        in_valid = 1'b0;
        n_cmp++; if (acc != 2 * STAGES) begin n_fail++; $display("FAIL fill_accepted: got %0d want %0d", acc, 2 * STAGES); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL fill_occupancy: got %0d want 4", occupancy); end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h20) begin n_fail++; $display("FAIL fill_stable: got v=%b d=%h want v=1 d=20", out_valid, out_data); end
        end
        out_ready = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (fo) begin
                exp_d = (q.size() > 0) ? q.pop_front() : 'x;
                n_cmp++; if (od !== exp_d) begin n_fail++; $display("FAIL drain_data: got %h want %h", od, exp_d); end
            end
            if (c == 1) begin
                n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL drain_ready_c1: got %b want 0", in_ready); end
            end
            if (c == 2) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready_c2: got %b want 1", in_ready); end
            end
        end
        n_cmp++; if (q.size() != 0 || occupancy !== 3'd0) begin n_fail++; $display("FAIL drain_empty: got left=%0d occ=%0d want 0/0", q.size(), occupancy); end
    endtask

    task automatic test_occ3();
        logic [CNT_W-1:0] prev;
        int both = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 10 && occupancy != 3'd3; c++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            tick();
            if (fi) q.push_back(id);
        end
        n_cmp++; if (occupancy !== 3'd3 || q.size() != 3) begin n_fail++; $display("FAIL occ3_reach: got occ=%0d held=%0d want 3/3", occupancy, q.size()); end
        for (int c = 0; c < 12; c++) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            in_data   = W'($urandom);
            prev      = occupancy;
            tick();
            if (fo) begin
                exp_d = (q.size() > 0) ? q.pop_front() : 'x;
                n_cmp++; if (od !== exp_d) begin n_fail++; $display("FAIL occ3_data: got %h want %h", od, exp_d); end
            end
            if (fi) q.push_back(id);
            if (fi && fo) begin
                both++;
                n_cmp++; if (occupancy !== prev) begin n_fail++; $display("FAIL occ3_hold: got %0d want %0d", occupancy, prev); end
            end
            n_cmp++; if (occupancy !== CNT_W'(q.size())) begin n_fail++; $display("FAIL occ3_count: got %0d want %0d", occupancy, q.size()); end
        end
        n_cmp++; if (both == 0) begin n_fail++; $display("FAIL occ3_both: got 0 simultaneous transfers want >0"); end
        in_valid = 1'b0;
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            tick();
            if (fo) begin
                exp_d = q.pop_front();
                n_cmp++; if (od !== exp_d) begin n_fail++; $display("FAIL occ3_drain: got %h want %h", od, exp_d); end
            end
        end
        n_cmp++; if (q.size() != 0) begin n_fail++; $display("FAIL occ3_left: got %0d want 0", q.size()); end
    endtask

    task automatic test_random();
        int pushed = 0;
        int cyc = 0;
        logic ir0;
        while ((pushed < 10000 || q.size() > 0) && cyc < 80000) begin
            in_valid  = (pushed < 10000) ? 1'($urandom) : 1'b0;
            out_ready = 1'($urandom);
            in_data   = W'($urandom);
            if (cyc % 16 == 0) begin
                ir0 = in_ready;
                out_ready = ~out_ready;
                #2;
                n_cmp++; if (in_ready !== ir0) begin n_fail++; $display("FAIL rnd_ready_comb: got %b want %b", in_ready, ir0); end
                out_ready = ~out_ready;
            end
            tick();
            cyc++;
            if (fo) begin
                exp_d = (q.size() > 0) ? q.pop_front() : 'x;
                n_cmp++; if (od !== exp_d) begin n_fail++; $display("FAIL rnd_data: got %h want %h", od, exp_d); end
            end
            if (fi) begin q.push_back(id); pushed++; end
            n_cmp++; if (occupancy !== CNT_W'(q.size())) begin n_fail++; $display("FAIL rnd_occupancy: got %0d want %0d", occupancy, q.size()); end
        end
        n_cmp++; if (pushed != 10000 || q.size() != 0) begin n_fail++; $display("FAIL rnd_complete: got pushed=%0d left=%0d want 10000/0", pushed, q.size()); end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int c = 0; c < 10 && occupancy != 3'd3; c++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if (occupancy !== 3'd3) begin n_fail++; $display("FAIL rmid_hold: got %0d want 3", occupancy); end
        #3 rst = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rmid_occupancy: got %0d want 0", occupancy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
        q.delete();
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (!fi || out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_first: got acc=%b v=%b want acc=1 v=0", fi, out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin n_fail++; $display("FAIL rmid_a5: got v=%b d=%h want v=1 d=a5", out_valid, out_data); end
        tick();
    endtask

`ifdef SKID_PIPE_FLUSH_EN
    task automatic test_flush();
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_data  = W'(32'h30 + c);
            tick();
        end
        n_cmp++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL flush_fill: got %0d want 4", occupancy); end
        in_data = 8'h77;
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL flush_occupancy: got %0d want 0", occupancy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak: got v=%b d=%h want v=0", out_valid, out_data); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_fill_drain();
        test_occ3();
        test_random();
        test_reset_mid();
`ifdef SKID_PIPE_FLUSH_EN
        test_flush();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
